mem_port_arbiter: RTL and testbench

- Arbitrates one single-port synchronous memory between instruction fetch (I) and data load/store (D) requesters of the five-stage core inside the minimal SOPC.
- Latches the granted request and drives the memory for a fixed number of wait cycles.
- Returns read data with a one-cycle ack, and raises per-port stall requests toward the pipeline control unit.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction-fetch (I) and data (D) requesters.
// Each transfer latches the winning request, holds the memory for WAIT_CYCLES cycles, then acks.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_sel,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              m_ce,
   output logic              m_we,
   output logic [3:0]        m_sel,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              stallreq_i,
   output logic              stallreq_d
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              portD_q;
   logic [1:0]        dStreak_q;
   logic [1:0]        dStreak_d;
   logic              iAck_q;
   logic              dAck_q;
   logic [DATA_W-1:0] iRdata_q;
   logic [DATA_W-1:0] dRdata_q;
   logic              mCe_q;
   logic              mWe_q;
   logic [3:0]        mSel_q;
   logic [ADDR_W-1:0] mAddr_q;
   logic [DATA_W-1:0] mWdata_q;
   logic              grantD;
   logic              grantI;

   // D normally wins, but after two consecutive D wins against a waiting I, I gets its turn.
   always_comb begin
      grantD    = (state_q == IDLE) && d_req && !(i_req && (dStreak_q == 2'd2));
      grantI    = (state_q == IDLE) && i_req && !grantD;
      dStreak_d = dStreak_q;
      if (grantI) begin
         dStreak_d = 2'd0;
      end else if (grantD) begin
         if (!i_req) begin
            dStreak_d = 2'd0;
         end else if (dStreak_q != 2'd2) begin
            dStreak_d = dStreak_q + 2'd1;
         end
      end
   end

   // Memory-side outputs are zero outside ACCESS so the memory only ever sees the latched request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         portD_q   <= 1'b0;
         dStreak_q <= 2'd0;
         iAck_q    <= 1'b0;
         dAck_q    <= 1'b0;
         iRdata_q  <= '0;
         dRdata_q  <= '0;
         mCe_q     <= 1'b0;
         mWe_q     <= 1'b0;
         mSel_q    <= 4'd0;
         mAddr_q   <= '0;
         mWdata_q  <= '0;
      end else begin
         iAck_q    <= 1'b0;
         dAck_q    <= 1'b0;
         dStreak_q <= dStreak_d;
         case (state_q)
            IDLE: begin
               if (grantD) begin
                  portD_q  <= 1'b1;
                  mCe_q    <= 1'b1;
                  mWe_q    <= d_we;
                  mSel_q   <= d_sel;
                  mAddr_q  <= d_addr;
                  mWdata_q <= d_wdata;
                  cnt_q    <= 4'd0;
                  state_q  <= ACCESS;
               end else if (grantI) begin
                  portD_q  <= 1'b0;
                  mCe_q    <= 1'b1;
                  mWe_q    <= 1'b0;
                  mSel_q   <= 4'b1111;
                  mAddr_q  <= i_addr;
                  mWdata_q <= '0;
                  cnt_q    <= 4'd0;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == LAST_CNT) begin
                  if (!mWe_q) begin
                     if (portD_q) begin
                        dRdata_q <= m_rdata;
                     end else begin
                        iRdata_q <= m_rdata;
                     end
                  end
                  iAck_q   <= !portD_q;
                  dAck_q   <= portD_q;
                  mCe_q    <= 1'b0;
                  mWe_q    <= 1'b0;
                  mSel_q   <= 4'd0;
                  mAddr_q  <= '0;
                  mWdata_q <= '0;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_rdata    = iRdata_q;
   assign d_rdata    = dRdata_q;
   assign i_ack      = iAck_q;
   assign d_ack      = dAck_q;
   assign m_ce       = mCe_q;
   assign m_we       = mWe_q;
   assign m_sel      = mSel_q;
   assign m_addr     = mAddr_q;
   assign m_wdata    = mWdata_q;
   assign stallreq_i = i_req & ~iAck_q;
   assign stallreq_d = d_req & ~dAck_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two builds (WAIT_CYCLES=2 and 1) checked every cycle against a
// timeline-based model of grants, access windows and acks, plus directed scenarios.
module tb_mem_port_arbiter;

   localparam int WC0 = 2;
   localparam int WC1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iReq   [2];
   logic [31:0] iAddr  [2];
   logic [31:0] iRdata [2];
   logic        iAck   [2];
   logic        dReq   [2];
   logic        dWe    [2];
   logic [3:0]  dSel   [2];
   logic [31:0] dAddr  [2];
   logic [31:0] dWdata [2];
   logic [31:0] dRdata [2];
   logic        dAck   [2];
   logic        mCe    [2];
   logic        mWe    [2];
   logic [3:0]  mSel   [2];
   logic [31:0] mAddr  [2];
   logic [31:0] mWdata [2];
   logic [31:0] mRdata [2];
   logic        stallI [2];
   logic        stallD [2];

   typedef struct {
      bit          busy;
      int          g;
      bit          portD;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] iRdata;
      logic [31:0] dRdata;
      int          streak;
   } model_t;

   model_t mdl [2];
   int     edgeNo = 0;
   int     errors = 0;
   int     checks = 0;
   bit     randOn = 0;
   bit     logOn  = 0;
   bit     logPort [$];
   int     logEdge [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] romWord(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h3401_1100;
      return {a[15:0] ^ 16'hA5C3, ~a[15:0]} + 32'h0101_0101;
   endfunction

   assign mRdata[0] = romWord(mAddr[0]);
   assign mRdata[1] = romWord(mAddr[1]);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC0)) dut0 (
      .clk(clk), .rst(rst),
      .i_req(iReq[0]), .i_addr(iAddr[0]), .i_rdata(iRdata[0]), .i_ack(iAck[0]),
      .d_req(dReq[0]), .d_we(dWe[0]), .d_sel(dSel[0]), .d_addr(dAddr[0]),
      .d_wdata(dWdata[0]), .d_rdata(dRdata[0]), .d_ack(dAck[0]),
      .m_ce(mCe[0]), .m_we(mWe[0]), .m_sel(mSel[0]), .m_addr(mAddr[0]),
      .m_wdata(mWdata[0]), .m_rdata(mRdata[0]),
      .stallreq_i(stallI[0]), .stallreq_d(stallD[0])
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC1)) dut1 (
      .clk(clk), .rst(rst),
      .i_req(iReq[1]), .i_addr(iAddr[1]), .i_rdata(iRdata[1]), .i_ack(iAck[1]),
      .d_req(dReq[1]), .d_we(dWe[1]), .d_sel(dSel[1]), .d_addr(dAddr[1]),
      .d_wdata(dWdata[1]), .d_rdata(dRdata[1]), .d_ack(dAck[1]),
      .m_ce(mCe[1]), .m_we(mWe[1]), .m_sel(mSel[1]), .m_addr(mAddr[1]),
      .m_wdata(mWdata[1]), .m_rdata(mRdata[1]),
      .stallreq_i(stallI[1]), .stallreq_d(stallD[1])
   );

   function automatic int wOf(input int j);
      return (j == 0) ? WC0 : WC1;
   endfunction

   task automatic modelReset(input int j);
      mdl[j].busy   = 0;
      mdl[j].g      = 0;
      mdl[j].portD  = 0;
      mdl[j].we     = 0;
      mdl[j].sel    = 4'd0;
      mdl[j].addr   = '0;
      mdl[j].wdata  = '0;
      mdl[j].iRdata = '0;
      mdl[j].dRdata = '0;
      mdl[j].streak = 0;
   endtask

   // A transfer granted at edge g occupies the memory after edges g..g+W-1, acks after edge g+W,
   // and the port is free to arbitrate again at edge g+W+2.
   task automatic modelStep(input int j);
      int  d;
      bit  wantD;
      if (rst) begin
         modelReset(j);
         return;
      end
      d = edgeNo - mdl[j].g;
      if (mdl[j].busy) begin
         if (d == wOf(j) && !mdl[j].we) begin
            if (mdl[j].portD) mdl[j].dRdata = romWord(mdl[j].addr);
            else              mdl[j].iRdata = romWord(mdl[j].addr);
         end
         if (d == wOf(j) + 1) mdl[j].busy = 0;
      end else begin
         wantD = dReq[j] && !(iReq[j] && mdl[j].streak == 2);
         if (wantD || iReq[j]) begin
            mdl[j].busy  = 1;
            mdl[j].g     = edgeNo;
            mdl[j].portD = wantD;
            mdl[j].we    = wantD ? dWe[j] : 1'b0;
            mdl[j].sel   = wantD ? dSel[j] : 4'b1111;
            mdl[j].addr  = wantD ? dAddr[j] : iAddr[j];
            mdl[j].wdata = wantD ? dWdata[j] : 32'd0;
            if (wantD && iReq[j]) mdl[j].streak = (mdl[j].streak < 2) ? mdl[j].streak + 1 : 2;
            else                  mdl[j].streak = 0;
            if (logOn && j == 0) begin
               logPort.push_back(wantD);
               logEdge.push_back(edgeNo);
            end
         end
      end
   endtask

   function automatic bit inAccess(input int j);
      int d = edgeNo - mdl[j].g;
      return mdl[j].busy && d >= 0 && d < wOf(j);
   endfunction

   function automatic bit expAck(input int j, input bit portD);
      return mdl[j].busy && (edgeNo - mdl[j].g) == wOf(j) && mdl[j].portD == portD;
   endfunction

   task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d] @edge %0d: got %h expected %h", name, j, edgeNo, act, exp);
      end
   endtask

   task automatic checkOutput(input int j);
      bit acc = inAccess(j);
      chk("m_ce",     j, 32'(mCe[j]),   32'(acc));
      chk("m_we",     j, 32'(mWe[j]),   acc ? 32'(mdl[j].we) : 32'd0);
      chk("m_sel",    j, 32'(mSel[j]),  acc ? 32'(mdl[j].sel) : 32'd0);
      chk("m_addr",   j, mAddr[j],      acc ? mdl[j].addr : 32'd0);
      chk("m_wdata",  j, mWdata[j],     acc ? mdl[j].wdata : 32'd0);
      chk("i_ack",    j, 32'(iAck[j]),  32'(expAck(j, 0)));
      chk("d_ack",    j, 32'(dAck[j]),  32'(expAck(j, 1)));
      chk("i_rdata",  j, iRdata[j],     mdl[j].iRdata);
      chk("d_rdata",  j, dRdata[j],     mdl[j].dRdata);
      chk("stallreq_i", j, 32'(stallI[j]), 32'(iReq[j] & ~expAck(j, 0)));
      chk("stallreq_d", j, 32'(stallD[j]), 32'(dReq[j] & ~expAck(j, 1)));
   endtask

   // Requesters mostly hold until ack, occasionally drop early; payloads churn every cycle.
   task automatic applyStimulus(input int j);
      if (iReq[j] && expAck(j, 0))  iReq[j] = ($urandom_range(3) == 0);
      else if (!iReq[j])            iReq[j] = ($urandom_range(2) == 0);
      else if ($urandom_range(31) == 0) iReq[j] = 1'b0;
      if (dReq[j] && expAck(j, 1))  dReq[j] = ($urandom_range(3) == 0);
      else if (!dReq[j])            dReq[j] = ($urandom_range(2) == 0);
      else if ($urandom_range(31) == 0) dReq[j] = 1'b0;
      iAddr[j]  = $urandom & 32'h0000_00FC;
      dAddr[j]  = $urandom;
      dWe[j]    = 1'($urandom_range(1));
      dSel[j]   = 4'($urandom);
      dWdata[j] = $urandom;
   endtask

   task automatic cycle();
      @(posedge clk);
      edgeNo++;
      for (int j = 0; j < 2; j++) modelStep(j);
      @(negedge clk);
      for (int j = 0; j < 2; j++) checkOutput(j);
      if (randOn) for (int j = 0; j < 2; j++) applyStimulus(j);
   endtask

   initial begin
      int ceCount, weCount, acks, acks1, firstAck1, secondAck1;
      bit expOrder [6];
      expOrder = '{1, 1, 0, 1, 1, 0};
      for (int j = 0; j < 2; j++) begin
         iReq[j] = 0; iAddr[j] = '0; dReq[j] = 0; dWe[j] = 0;
         dSel[j] = 4'd0; dAddr[j] = '0; dWdata[j] = '0;
         modelReset(j);
      end
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      chk("reset_i_rdata", 0, iRdata[0], 32'd0);
      chk("reset_m_ce", 0, 32'(mCe[0]), 32'd0);

      // I read at 0x10 on the W=2 build; back-to-back I reads at 0x0, 0x4 on the W=1 build.
      iReq[0] = 1; iAddr[0] = 32'h10;
      iReq[1] = 1; iAddr[1] = 32'h0;
      ceCount = 0; acks1 = 0; firstAck1 = 0; secondAck1 = 0;
      for (int n = 0; n < 12; n++) begin
         cycle();
         ceCount += int'(mCe[0]);
         if (iAck[0]) iReq[0] = 0;
         if (iAck[1]) begin
            acks1++;
            if (acks1 == 1) begin
               firstAck1 = edgeNo;
               iAddr[1] = 32'h4;
            end else if (acks1 == 2) begin
               secondAck1 = edgeNo;
               iReq[1] = 0;
            end
         end
      end
      chk("iread_rdata", 0, iRdata[0], 32'h3401_1100);
      chk("iread_ce_cycles", 0, 32'(ceCount), 32'd2);
      chk("w1_ack_count", 1, 32'(acks1), 32'd2);
      chk("w1_ack_spacing", 1, 32'(secondAck1 - firstAck1), 32'd3);
      chk("w1_rdata", 1, iRdata[1], romWord(32'h4));

      // D write on the W=2 build; d_rdata must stay untouched.
      dReq[0] = 1; dWe[0] = 1; dSel[0] = 4'b0011; dAddr[0] = 32'h40; dWdata[0] = 32'hDEAD_BEEF;
      weCount = 0; acks = 0;
      for (int n = 0; n < 8; n++) begin
         cycle();
         if (mCe[0] && mWe[0] && mSel[0] == 4'b0011 && mWdata[0] == 32'hDEAD_BEEF && mAddr[0] == 32'h40)
            weCount++;
         if (dAck[0]) begin
            acks++;
            dReq[0] = 0;
         end
      end
      chk("dwrite_cycles", 0, 32'(weCount), 32'd2);
      chk("dwrite_acks", 0, 32'(acks), 32'd1);
      chk("dwrite_rdata", 0, dRdata[0], 32'd0);

      // Requester drops d_req in the first ACCESS cycle; the write must still complete.
      dReq[0] = 1; dWe[0] = 1; dSel[0] = 4'hF; dAddr[0] = 32'h44; dWdata[0] = 32'h1234_5678;
      weCount = 0; acks = 0;
      for (int n = 0; n < 7; n++) begin
         cycle();
         if (n == 0) dReq[0] = 0;
         if (mCe[0] && mWe[0] && mAddr[0] == 32'h44 && mWdata[0] == 32'h1234_5678) weCount++;
         acks += int'(dAck[0]);
      end
      chk("drop_cycles", 0, 32'(weCount), 32'd2);
      chk("drop_acks", 0, 32'(acks), 32'd1);

      // Both ports held high: expect D, D, I repeating, one grant every 4 cycles.
      logPort.delete(); logEdge.delete();
      logOn = 1;
      iReq[0] = 1; iAddr[0] = 32'h8;
      dReq[0] = 1; dWe[0] = 0; dSel[0] = 4'hF; dAddr[0] = 32'h10;
      repeat (24) cycle();
      logOn = 0;
      iReq[0] = 0; dReq[0] = 0;
      repeat (5) cycle();
      chk("contend_grants", 0, 32'(logPort.size()), 32'd6);
      if (logPort.size() == 6) begin
         for (int k = 0; k < 6; k++) chk("contend_order", k, 32'(logPort[k]), 32'(expOrder[k]));
         for (int k = 1; k < 6; k++) chk("contend_spacing", k, 32'(logEdge[k] - logEdge[k-1]), 32'd4);
      end
      chk("contend_d_rdata", 0, dRdata[0], 32'h3401_1100);

      // Asynchronous reset in the middle of an access.
      iReq[0] = 1; iAddr[0] = 32'h20;
      cycle();
      cycle();
      chk("pre_reset_ce", 0, 32'(mCe[0]), 32'd1);
      rst = 1'b1;
      #1;
      modelReset(0);
      modelReset(1);
      chk("async_m_ce", 0, 32'(mCe[0]), 32'd0);
      chk("async_i_ack", 0, 32'(iAck[0]), 32'd0);
      chk("async_i_rdata", 0, iRdata[0], 32'd0);
      chk("async_d_rdata", 0, dRdata[0], 32'd0);
      iReq[0] = 0;
      cycle();
      rst = 1'b0;
      acks = 0;
      for (int n = 0; n < 5; n++) begin
         cycle();
         acks += int'(iAck[0]) + int'(dAck[0]);
      end
      chk("post_reset_acks", 0, 32'(acks), 32'd0);

      randOn = 1;
      repeat (3000) cycle();
      randOn = 0;
      for (int j = 0; j < 2; j++) begin
         iReq[j] = 0;
         dReq[j] = 0;
      end
      repeat (6) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
